// File: rtl/led_pkg.sv
// Constants and types shared by the LED decoder and the key encoder.
package led_pkg;

  localparam int unsigned LED_N      = 8;
  localparam int unsigned LED_CODE_W = 3;

  // The decoder and the encoder are both live only under this enable code.
  localparam logic [2:0] ENABLE_ACTIVE = 3'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } pres_state_e;

endpackage

// File: rtl/sync_fall_detect.sv
// Multi-stage synchronizer for idle-high lines with a falling-edge detector.
module sync_fall_detect
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = LED_N,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] evt
);

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] prev_q;

  // Everything resets high so that releasing reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sync_q[i] <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign evt = prev_q & ~sync_q[DEPTH-1];

endmodule

// File: rtl/key_encoder.sv
// Captures falling edges on active-low request lines and presents the highest
// pending index as a code through a valid/ack handshake.
module key_encoder
  import led_pkg::*;
#(
  parameter int unsigned N           = LED_N,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           enable,
  input  logic [N-1:0]         req_n,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] code,
  output logic                 valid,
  output logic                 pending_any
);

  localparam int unsigned CODE_W = $clog2(N);

  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("SYNC_STAGES must be at least 2");
  end

  logic [N-1:0]      evt;
  logic [N-1:0]      set_mask;
  logic [N-1:0]      clr_mask;
  logic [N-1:0]      pending_q, pending_d;
  logic [CODE_W-1:0] win;
  logic [CODE_W-1:0] code_q, code_d;
  logic              pending_any_q;
  pres_state_e       state_q, state_d;

  sync_fall_detect #(
    .WIDTH (N),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (req_n),
    .evt (evt)
  );

  // Later (higher) indices overwrite earlier ones, so the MSB wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) win = CODE_W'(i);
    end
  end

  // Set is applied after clear so a same-cycle event re-pends the acked bit.
  always_comb begin
    set_mask = (enable == ENABLE_ACTIVE) ? evt : '0;
    clr_mask = '0;
    if (state_q == SHOW && ack) clr_mask[code_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          code_d  = win;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      pending_any_q <= 1'b0;
      code_q        <= '0;
      state_q       <= IDLE;
    end else begin
      pending_q     <= pending_d;
      pending_any_q <= |pending_d;
      code_q        <= code_d;
      state_q       <= state_d;
    end
  end

  assign code        = code_q;
  assign valid       = (state_q == SHOW);
  assign pending_any = pending_any_q;

endmodule

// File: tb/tb_key_encoder.sv
// Directed and randomized checks of the key encoder capture and handshake.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] enable = 3'd4;
  logic [7:0] req_n = 8'hFF;
  logic       ack = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic       pending_any;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_n       (req_n),
    .ack         (ack),
    .code        (code),
    .valid       (valid),
    .pending_any (pending_any)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    req_n  = 8'hFF;
    ack    = 1'b0;
    enable = 3'd4;
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1);
    checks++;
    if ({valid, code, pending_any} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b code=%0d pany=%0b, want 0 0 0",
               valid, code, pending_any);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    req_n = 8'hF7;
    tick(2);
    checks++;
    if (pending_any !== 1'b0) begin
      errors++;
      $display("FAIL single_e1: pending_any=%0b want 0", pending_any);
    end
    tick(1);
    checks++;
    if (pending_any !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e2: pany=%0b valid=%0b want 1 0", pending_any, valid);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || code !== 3'd3) begin
      errors++;
      $display("FAIL single_e3: valid=%0b code=%0d want 1 3", valid, code);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: valid=%0b pany=%0b want 0 0", valid, pending_any);
    end
    tick(5);
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL single_held: valid=%0b pany=%0b want 0 0", valid, pending_any);
    end
  endtask

  task automatic test_priority();
    settle();
    req_n = 8'hDD;
    tick(4);
    checks++;
    if (valid !== 1'b1 || code !== 3'd5) begin
      errors++;
      $display("FAIL prio_first: valid=%0b code=%0d want 1 5", valid, code);
    end
    req_n = 8'h5D;
    tick(4);
    checks++;
    if (valid !== 1'b1 || code !== 3'd5) begin
      errors++;
      $display("FAIL prio_no_preempt: valid=%0b code=%0d want 1 5", valid, code);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_gap1: valid=%0b want 0", valid);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || code !== 3'd7) begin
      errors++;
      $display("FAIL prio_second: valid=%0b code=%0d want 1 7", valid, code);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b1) begin
      errors++;
      $display("FAIL prio_gap2: valid=%0b pany=%0b want 0 1", valid, pending_any);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || code !== 3'd1) begin
      errors++;
      $display("FAIL prio_third: valid=%0b code=%0d want 1 1", valid, code);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL prio_drained: valid=%0b pany=%0b want 0 0", valid, pending_any);
    end
  endtask

  task automatic test_enable_gating();
    settle();
    enable = 3'd2;
    req_n  = 8'hEF;
    tick(6);
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL gate_disabled: valid=%0b pany=%0b want 0 0", valid, pending_any);
    end
    enable = 3'd4;
    tick(4);
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL gate_not_deferred: valid=%0b pany=%0b want 0 0", valid, pending_any);
    end
    req_n = 8'hFF;
    tick(4);
    req_n = 8'hEF;
    tick(4);
    checks++;
    if (valid !== 1'b1 || code !== 3'd4) begin
      errors++;
      $display("FAIL gate_repress: valid=%0b code=%0d want 1 4", valid, code);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic test_collision();
    settle();
    req_n = 8'hFB;
    tick(4);
    checks++;
    if (valid !== 1'b1 || code !== 3'd2) begin
      errors++;
      $display("FAIL coll_shown: valid=%0b code=%0d want 1 2", valid, code);
    end
    req_n = 8'hFF;
    tick(3);
    req_n = 8'hFB;
    tick(2);
    // The new event is visible now and is captured at the ack edge.
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending_any !== 1'b1) begin
      errors++;
      $display("FAIL coll_ack_edge: valid=%0b pany=%0b want 0 1", valid, pending_any);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || code !== 3'd2) begin
      errors++;
      $display("FAIL coll_repend: valid=%0b code=%0d want 1 2", valid, code);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen;
    settle();
    req_n = 8'hBF;
    tick(4);
    checks++;
    if (valid !== 1'b1 || code !== 3'd6) begin
      errors++;
      $display("FAIL areset_pre: valid=%0b code=%0d want 1 6", valid, code);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || code !== 3'd0 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: valid=%0b code=%0d pany=%0b want 0 0 0",
               valid, code, pending_any);
    end
    req_n = 8'hFF;
    tick(2);
    #3 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (valid !== 1'b0 || pending_any !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL areset_release: activity seen=%0b want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [7:0] m_s0, m_s1, m_prev, m_pend, m_set, m_clr, m_npend;
    logic       m_st, m_pany;
    logic [2:0] m_code;
    int         captures, dut_accepts, b;

    rst = 1'b1;
    req_n = 8'hFF;
    ack = 1'b0;
    enable = 3'd4;
    tick(1);
    rst = 1'b0;
    m_s0 = 8'hFF; m_s1 = 8'hFF; m_prev = 8'hFF; m_pend = '0;
    m_st = 1'b0; m_pany = 1'b0; m_code = '0;
    captures = 0;
    dut_accepts = 0;

    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = int'($urandom_range(0, 7));
        req_n[b] = ~req_n[b];
      end
      enable = ($urandom_range(0, 5) != 0) ? 3'd4 : 3'($urandom_range(0, 7));
      ack = 1'($urandom_range(0, 1));
      if (valid === 1'b1 && ack) dut_accepts++;

      m_set = (enable == 3'd4) ? (m_prev & ~m_s1) : 8'h00;
      m_clr = (m_st && ack) ? (8'h01 << m_code) : 8'h00;
      m_npend = (m_pend & ~m_clr) | m_set;
      captures += $countones(m_set & ~(m_pend & ~m_clr));
      if (!m_st) begin
        if (m_pend != 8'h00) begin
          for (int k = 7; k >= 0; k--) begin
            if (m_pend[k]) begin
              m_code = 3'(k);
              break;
            end
          end
          m_st = 1'b1;
        end
      end else if (ack) begin
        m_st = 1'b0;
      end
      m_prev = m_s1;
      m_s1   = m_s0;
      m_s0   = req_n;
      m_pend = m_npend;
      m_pany = |m_npend;

      tick(1);
      checks++;
      if (valid !== m_st || pending_any !== m_pany || (m_st && code !== m_code)) begin
        errors++;
        $display("FAIL rand_cycle%0d: valid=%0b code=%0d pany=%0b want %0b %0d %0b",
                 c, valid, code, pending_any, m_st, m_code, m_pany);
      end
    end
    ack = 1'b0;
    checks++;
    if (dut_accepts + $countones(m_pend) != captures) begin
      errors++;
      $display("FAIL rand_conservation: accepted+pending=%0d want captures=%0d",
               dut_accepts + $countones(m_pend), captures);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_enable_gating();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_encoder.md
# key_encoder

Inverse of the LED 3-to-8 decoder: accepts eight active-low request lines (idle high, same polarity as `led`), detects assertion events, queues them, and presents the highest-index pending request as a 3-bit code with a valid/ack handshake. Sits between the board's key or switch inputs and the control logic that drives the decoder's `switch` input. Gated by the same `enable == 3'd4` condition the decoder uses.

## Interface
- `N`, 8: number of request lines.
- `CODE_W`, `$clog2(N)` (3): output code width; derived, not overridden.
- `SYNC_STAGES`, 2: synchronizer depth on `req_n`; minimum 2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `enable`  input  3  capture enabled only when equal to 3'd4.
- `req_n`  input  N  asynchronous request lines, active-low, idle 1.
- `ack`  input  1  consumer accepts the presented code; meaningful only while `valid`=1.
- `code`  output  CODE_W  index of presented request; registered.
- `valid`  output  1  `code` is valid; registered.
- `pending_any`  output  1  OR of the pending register; registered.

## Operation
- Synchronizer: `SYNC_STAGES` flops per line; reset value all 1s so reset release generates no event.
- Event detect: `prev` flop holds the last synchronized value; event[i] = prev[i] & ~sync[i] (1→0 transition). Held-low lines produce one event only.
- Capture: at a clock edge with `enable`==3'd4, pending |= event. With any other `enable` value, events are discarded (not deferred); pending, handshake, and `prev` tracking continue unaffected.
- Priority: highest set index in pending wins (bit 7 highest).
- Presenter states: IDLE (valid=0) and SHOW (valid=1).
  - IDLE: if pending≠0, load `code` with the winning index, go to SHOW.
  - SHOW: `code` held stable and not pre-empted by higher-index arrivals. When `ack`=1: clear pending[code], valid←0, go to IDLE.
- Simultaneous set and clear on the same bit in the same cycle: set wins, so the bit stays pending and is re-presented.
- Events on an already-pending bit merge; there is no counting.
- `ack` while valid=0 is ignored.
- `pending_any` reflects the pending register after the current edge's updates, registered.

## Timing
- Reset values (asynchronous): sync and `prev` = all 1s, pending = 0, `code` = 0, `valid` = 0, `pending_any` = 0, state = IDLE.
- Reset mid-handshake drops all pending events and the presented code immediately. No event is generated on release.
- Latency with `SYNC_STAGES`=2, where E0 is the first edge sampling `req_n[i]`=0:
  - E1: sync = 0, event true.
  - E2: pending set, `pending_any`=1.
  - E3: `valid`=1, `code`=i.
- Handshake: ack accepted at the edge where valid=1 and ack=1. `valid` is low for at least one cycle before the next code. Sustained throughput is one code per 2 cycles.
- Capture uses `enable` as sampled at the E2 edge.

## Structure
- Shared package `led_pkg`:
  - `LED_N` = 8.
  - `LED_CODE_W` = 3.
  - `ENABLE_ACTIVE` = 3'd4, shared with the decoder.
  - presenter state enum {IDLE, SHOW}.
- One sub-module, `sync_fall_detect`: parameterized width and depth, reset-to-1 synchronizer plus the `prev` flop, outputs `event`. Instantiated once, N wide.
- Top level holds the pending register, the priority selector (combinational, loop from the LSB so the highest index wins), and the presenter FSM.

## Test plan
- Single request: rst pulse, enable=4, req_n=8'hF7 held → `pending_any`=1 at E2, `valid`=1 with `code`=3 at E3; ack one cycle → `valid`=0, pending cleared, no further valid while line held low.
- Priority and no pre-emption: req_n bits 1 and 5 fall together → code 5 first. Bit 7 falls while 5 is shown → 5 held until ack, then 7, then 1, each separated by a valid=0 cycle.
- Enable gating: enable=3'd2 while bit 4 falls → no pending, valid stays 0. Set enable=4 afterward with bit 4 still low → still nothing; release and re-press → code 4.
- Set/clear collision: code 2 shown, bit 2 released and re-pressed so its event lands on the ack edge → valid drops one cycle, then code 2 presented again.
- Async reset mid-SHOW: rst asserted between clock edges while valid=1, code=6 → valid=0, code=0, pending_any=0 immediately. After release with all lines high → no valid for 10 cycles.
- Randomized stress: random req_n, enable and ack over 1000 cycles, checked against a behavioural model of pending and priority → every accepted code corresponds to a distinct captured event, with no loss and no duplication except re-pend after a collision.
